// File: rtl/mat_pkg.sv
// Shared definitions for the matrix-multiply datapath: state encoding and
// beat geometry helpers, so loaders and the result streamer agree on
// element ordering (element e = row*N+col, lowest index in the lowest lane).
package mat_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } mat_state_t;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int mat_clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  // Number of output beats needed to drain one N*N result.
  function automatic int mat_beats(input int n, input int lanes);
    return (n * n) / lanes;
  endfunction

  // Beat counter width; a single-beat matrix still needs a 1-bit counter.
  function automatic int mat_beat_width(input int beats);
    return (mat_clog2(beats) < 1) ? 1 : mat_clog2(beats);
  endfunction

endpackage

// File: rtl/mat_result_streamer.sv
// Purpose: captures a full N*N result on valid_in and drains it as LANES-wide beats with m_last.
// Latency: first beat is valid 1 cycle after capture; back-to-back matrices chain without a bubble.
// Backpressure: m_data/m_last hold while m_ready is low; a result arriving mid-drain is dropped and flags overrun.
module mat_result_streamer
  import mat_pkg::*;
#(
  parameter int W_OUT = 32,
  parameter int N     = 8,
  parameter int LANES = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     valid_in,
  input  logic [N*N*W_OUT-1:0]     result_in,
  output logic [LANES*W_OUT-1:0]   m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic                     busy,
  output logic                     overrun
);

  localparam int BEATS  = mat_beats(N, LANES);
  localparam int BW     = mat_beat_width(BEATS);
  localparam int BEAT_W = LANES * W_OUT;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  mat_state_t            state_q;
  mat_state_t            state_d;
  logic [BW-1:0]         beat_q;
  logic [N*N*W_OUT-1:0]  hold_q;
  logic                  overrun_q;

  logic sending;
  logic last_beat;
  logic xfer;
  logic xfer_last;
  logic capture;
  logic drop;

  assign sending   = (state_q == ST_SEND);
  assign last_beat = (beat_q == LAST_BEAT);
  assign xfer      = sending && m_ready;
  assign xfer_last = xfer && last_beat;
  // Accept a new result when idle, or when the final beat leaves this cycle.
  assign capture   = valid_in && (!sending || xfer_last);
  assign drop      = valid_in && sending && !xfer_last;

  // State register; reset discards any matrix in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave SEND only when the last beat goes out with nothing new arriving.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (valid_in) state_d = ST_SEND;
      ST_SEND: if (xfer_last && !valid_in) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Holding buffer, beat counter and sticky overrun flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_q    <= '0;
      beat_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (capture) begin
        hold_q <= result_in;
        beat_q <= '0;
      end else if (xfer && !last_beat) begin
        beat_q <= beat_q + BW'(1);
      end
      if (drop) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // Outputs depend on state only; payload is forced to zero when idle.
  always_comb begin
    m_valid = 1'b0;
    busy    = 1'b0;
    m_last  = 1'b0;
    m_data  = '0;
    overrun = overrun_q;
    if (sending) begin
      m_valid = 1'b1;
      busy    = 1'b1;
      m_last  = last_beat;
      m_data  = hold_q[int'(beat_q) * BEAT_W +: BEAT_W];
    end
  end

endmodule

// File: tb/tb_mat_result_streamer.sv
// Bench for mat_result_streamer: a directed per-cycle vector table on an
// N=2/LANES=2 instance, hand-written reset and single-beat sequences, and a
// randomized run of the default instance against a beat-queue reference model.
module tb_mat_result_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Small instance: N=2, LANES=2 -> 2 beats of 64 bits.
  logic         s_vin, s_rdy, s_vld, s_last, s_busy, s_ovr;
  logic [127:0] s_res;
  logic [63:0]  s_data;
  mat_result_streamer #(.W_OUT(32), .N(2), .LANES(2)) dut_s (
    .clk(clk), .resetn(resetn), .valid_in(s_vin), .result_in(s_res),
    .m_data(s_data), .m_valid(s_vld), .m_ready(s_rdy), .m_last(s_last),
    .busy(s_busy), .overrun(s_ovr));

  // Default instance: N=8, LANES=4 -> 16 beats of 128 bits.
  logic          d_vin, d_rdy, d_vld, d_last, d_busy, d_ovr;
  logic [2047:0] d_res;
  logic [127:0]  d_data;
  mat_result_streamer #(.W_OUT(32), .N(8), .LANES(4)) dut_d (
    .clk(clk), .resetn(resetn), .valid_in(d_vin), .result_in(d_res),
    .m_data(d_data), .m_valid(d_vld), .m_ready(d_rdy), .m_last(d_last),
    .busy(d_busy), .overrun(d_ovr));

  // Single-beat instance: N=2, LANES=4 -> 1 beat of 128 bits.
  logic         o_vin, o_rdy, o_vld, o_last, o_busy, o_ovr;
  logic [127:0] o_res;
  logic [127:0] o_data;
  mat_result_streamer #(.W_OUT(32), .N(2), .LANES(4)) dut_o (
    .clk(clk), .resetn(resetn), .valid_in(o_vin), .result_in(o_res),
    .m_data(o_data), .m_valid(o_vld), .m_ready(o_rdy), .m_last(o_last),
    .busy(o_busy), .overrun(o_ovr));

  // Matrix A = {0x11, 0xFFFFFFFB, 0x33, 0x44}, matrix B = {0xAA, 0xBB, 0xCC, 0xDD}.
  localparam logic [127:0] MA = 128'h00000044_00000033_FFFFFFFB_00000011;
  localparam logic [127:0] MB = 128'h000000DD_000000CC_000000BB_000000AA;
  localparam logic [63:0]  A0 = 64'hFFFFFFFB_00000011;
  localparam logic [63:0]  A1 = 64'h00000044_00000033;
  localparam logic [63:0]  B0 = 64'h000000BB_000000AA;
  localparam logic [63:0]  B1 = 64'h000000DD_000000CC;

  typedef struct {
    logic        vin;
    logic        sel_b;
    logic        rdy;
    logic        vld;
    logic        last;
    logic        ovr;
    logic [63:0] data;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic vin, input logic sel_b, input logic rdy,
                              input logic vld, input logic last, input logic ovr,
                              input logic [63:0] data);
    vec_t v;
    v.vin = vin; v.sel_b = sel_b; v.rdy = rdy;
    v.vld = vld; v.last = last; v.ovr = ovr; v.data = data;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model state for the randomized run.
  logic [127:0] q_data[$];
  logic         q_last[$];
  logic         m_ovr;
  logic [31:0]  elem[64];
  logic [127:0] exp_beat;

  initial begin
    resetn = 1'b0;
    s_vin = 0; s_rdy = 0; s_res = '0;
    d_vin = 0; d_rdy = 0; d_res = '0;
    o_vin = 0; o_rdy = 0; o_res = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset.m_valid", 128'(s_vld), 128'(0));
    chk("reset.m_last",  128'(s_last), 128'(0));
    chk("reset.busy",    128'(s_busy), 128'(0));
    chk("reset.overrun", 128'(s_ovr), 128'(0));
    chk("reset.m_data",  128'(s_data), 128'(0));
    chk("reset.d_m_valid", 128'(d_vld), 128'(0));
    @(negedge clk);
    resetn = 1'b1;

    // Per-cycle vectors: inputs driven this cycle, outputs expected this cycle.
    // Basic stream
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 64'h0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, A0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, A1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 64'h0));
    // Backpressure: 5 stalled cycles on beat0
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 64'h0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 0, 1, 0, 0, A0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, A0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, A1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 64'h0));
    // Seamless chaining: B arrives with A's final transfer
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 64'h0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, A0));
    tbl.push_back(mk(1, 1, 1, 1, 1, 0, A1));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, B0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, B1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 64'h0));
    // Overrun: B arrives while A's beat0 is stalled
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 64'h0));
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, A0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, A0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, A0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 1, A1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 64'h0));

    foreach (tbl[i]) begin
      @(negedge clk);
      s_vin = tbl[i].vin;
      s_res = tbl[i].sel_b ? MB : MA;
      s_rdy = tbl[i].rdy;
      #1;
      chk($sformatf("vec%0d.m_valid", i), 128'(s_vld),  128'(tbl[i].vld));
      chk($sformatf("vec%0d.busy", i),    128'(s_busy), 128'(tbl[i].vld));
      chk($sformatf("vec%0d.m_last", i),  128'(s_last), 128'(tbl[i].last));
      chk($sformatf("vec%0d.overrun", i), 128'(s_ovr),  128'(tbl[i].ovr));
      chk($sformatf("vec%0d.m_data", i),  128'(s_data), 128'(tbl[i].data));
    end

    // Reset mid-stream: assert between edges after beat0 has transferred
    @(negedge clk);
    s_vin = 1; s_res = MA; s_rdy = 1;
    @(negedge clk);
    s_vin = 0;
    #1;
    chk("rst_mid.beat0", 128'(s_data), 128'(A0));
    @(posedge clk);
    #2;
    chk("rst_mid.pre_last", 128'(s_last), 128'(1));
    resetn = 1'b0;
    #1;
    chk("rst_mid.m_valid", 128'(s_vld), 128'(0));
    chk("rst_mid.m_last",  128'(s_last), 128'(0));
    chk("rst_mid.busy",    128'(s_busy), 128'(0));
    chk("rst_mid.overrun", 128'(s_ovr), 128'(0));
    chk("rst_mid.m_data",  128'(s_data), 128'(0));
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    s_vin = 1; s_res = MB;
    @(negedge clk);
    s_vin = 0;
    #1;
    chk("rst_after.beat0", 128'(s_data), 128'(B0));
    chk("rst_after.last0", 128'(s_last), 128'(0));
    @(negedge clk);
    #1;
    chk("rst_after.beat1", 128'(s_data), 128'(B1));
    chk("rst_after.last1", 128'(s_last), 128'(1));
    @(negedge clk);
    #1;
    chk("rst_after.idle", 128'(s_vld), 128'(0));

    // Default geometry: element e = e, 16 beats, m_last only on beat 15
    for (int e = 0; e < 64; e++) d_res[e*32 +: 32] = 32'(e);
    @(negedge clk);
    d_vin = 1; d_rdy = 1;
    @(negedge clk);
    d_vin = 0;
    for (int k = 0; k < 16; k++) begin
      #1;
      exp_beat = '0;
      for (int j = 0; j < 4; j++) exp_beat[j*32 +: 32] = 32'(4*k + j);
      chk($sformatf("def.beat%0d.m_valid", k), 128'(d_vld), 128'(1));
      chk($sformatf("def.beat%0d.m_data", k), d_data, exp_beat);
      chk($sformatf("def.beat%0d.m_last", k), 128'(d_last), 128'(k == 15));
      @(negedge clk);
    end
    #1;
    chk("def.idle", 128'(d_vld), 128'(0));

    // Single-beat geometry: m_last high whenever valid, chaining without a bubble
    @(negedge clk);
    o_vin = 1; o_res = MA; o_rdy = 1;
    @(negedge clk);
    o_res = MB;
    #1;
    chk("one.a.m_valid", 128'(o_vld), 128'(1));
    chk("one.a.m_last",  128'(o_last), 128'(1));
    chk("one.a.m_data",  o_data, MA);
    @(negedge clk);
    o_vin = 0;
    #1;
    chk("one.b.m_data",  o_data, MB);
    chk("one.b.m_last",  128'(o_last), 128'(1));
    chk("one.b.overrun", 128'(o_ovr), 128'(0));
    @(negedge clk);
    #1;
    chk("one.idle", 128'(o_vld), 128'(0));

    // Randomized run of the default instance against the beat-queue model
    m_ovr = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      d_vin = ($urandom_range(0, 19) == 0);
      d_rdy = ($urandom_range(0, 9) < 7);
      for (int e = 0; e < 64; e++) begin
        elem[e] = $urandom;
        d_res[e*32 +: 32] = elem[e];
      end
      #1;
      chk($sformatf("rnd%0d.m_valid", c), 128'(d_vld), 128'(q_data.size() != 0));
      chk($sformatf("rnd%0d.busy", c), 128'(d_busy), 128'(q_data.size() != 0));
      chk($sformatf("rnd%0d.overrun", c), 128'(d_ovr), 128'(m_ovr));
      if (q_data.size() != 0) begin
        chk($sformatf("rnd%0d.m_data", c), d_data, q_data[0]);
        chk($sformatf("rnd%0d.m_last", c), 128'(d_last), 128'(q_last[0]));
      end
      // Advance the model across the coming clock edge
      if (q_data.size() != 0 && d_rdy) begin
        void'(q_data.pop_front());
        void'(q_last.pop_front());
      end
      if (d_vin) begin
        if (q_data.size() == 0) begin
          for (int k = 0; k < 16; k++) begin
            exp_beat = '0;
            for (int j = 0; j < 4; j++) exp_beat[j*32 +: 32] = elem[4*k + j];
            q_data.push_back(exp_beat);
            q_last.push_back(k == 15);
          end
        end else begin
          m_ovr = 1'b1;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mat_result_streamer.md
Name: mat_result_streamer

Overview:
- Drain side of the matrix-multiply datapath.
- Captures the wide N*N*W_OUT signed result bus when the multiplier pulses valid.
- Streams the captured result as LANES-element beats over a valid/ready interface with a last marker, for the SIMD writeback/DMA path.
- Reports when it is busy, and latches a sticky error if a new result arrives while a previous one is still draining.

Parameters:
- W_OUT, 32, bit width of one result element (two's complement, passed through unchanged).
- N, 8, matrix dimension; a result holds N*N elements.
- LANES, 4, elements per output beat. N*N must be divisible by LANES. BEATS = N*N/LANES (default 16).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- valid_in  in  1  one-cycle pulse; result_in is valid this cycle.
- result_in  in  N*N*W_OUT  packed result; element e = row*N+col at bits [e*W_OUT +: W_OUT].
- m_data  out  LANES*W_OUT  beat payload; lane j at bits [j*W_OUT +: W_OUT].
- m_valid  out  1  beat valid.
- m_ready  in  1  downstream accept.
- m_last  out  1  high on the final beat of a matrix.
- busy  out  1  high while a matrix is held or being streamed.
- overrun  out  1  sticky; a valid_in pulse was dropped.

Behaviour:
- Reset, asynchronous and immediate:
  - m_valid=0, m_last=0, busy=0, overrun=0, m_data=0.
  - State returns to IDLE and the beat counter goes to 0.
  - A matrix in flight is discarded. There is no partial resume.
- States: IDLE and SEND.
- IDLE:
  - On valid_in=1, register result_in into the holding buffer, set beat=0 and go to SEND.
  - m_valid rises the cycle after capture, so capture-to-first-beat latency is 1 cycle.
- SEND:
  - m_valid=1 and busy=1.
  - m_data = lanes of elements beat*LANES .. beat*LANES+LANES-1, lowest index in the low lane.
  - m_last = (beat == BEATS-1).
- Handshake:
  - A beat transfers on m_valid && m_ready.
  - While m_valid && !m_ready, m_data and m_last hold stable for any number of stall cycles.
  - m_valid never drops without a transfer.
- Beat advance: on a transfer with beat < BEATS-1, beat increments by 1.
- Final beat:
  - On a transfer with beat == BEATS-1 and valid_in=0: go to IDLE; m_valid and busy fall the next cycle.
  - If valid_in=1 in that same cycle: capture the new result, reset beat to 0 and stay in SEND. There is no bubble, and overrun is not set.
- Overrun: valid_in=1 in SEND, other than on the final-beat transfer, drops that input. The buffer is unchanged, and overrun goes to 1 and stays there until reset.
- Back-to-back: with m_ready held at 1, a matrix occupies exactly BEATS cycles of m_valid.
- Width rules:
  - No arithmetic on data; bits pass unchanged, so sign is preserved.
  - Beat counter width is clog2(BEATS), minimum 1.
  - BEATS=1 is legal: m_last is then constantly high while m_valid=1.
- X-safety: m_data is driven from the buffer only while in SEND and is 0 in IDLE.

Decomposition:
- Shared package mat_pkg holds:
  - the state encoding (ST_IDLE=0, ST_SEND=1);
  - a clog2 helper function;
  - the BEATS derivation, so mat_mul_wrapper-side loaders and this block agree on element ordering.
- Single module, no sub-module. The lane select is one indexed part-select of the buffer.

Test Plan (N=2, W_OUT=32, LANES=2 unless noted; BEATS=2):
- Basic stream:
  - Stimulus: result_in elements {0x11, 0xFFFFFFFB, 0x33, 0x44}, valid_in pulse, m_ready=1.
  - Response: beat0 m_data=0xFFFFFFFB_00000011 with m_last=0; beat1 m_data=0x00000044_00000033 with m_last=1; busy falls the next cycle.
- Backpressure:
  - Stimulus: m_ready=0 for 5 cycles after m_valid rises, then 1.
  - Response: beat0 held stable for all 5 cycles, then 2 transfers; no data change while stalled.
- Overrun:
  - Stimulus: second valid_in (elements 0xAA..) during beat0 of a stall.
  - Response: output is still the original 0x11.. matrix; overrun=1 and stays 1 after the stream completes.
- Seamless chaining:
  - Stimulus: second valid_in coincident with the final-beat transfer.
  - Response: next cycle m_valid=1 with the new beat0; overrun stays 0; 4 consecutive transfers in total.
- Reset mid-stream:
  - Stimulus: resetn=0 after beat0 transfers.
  - Response: m_valid/m_last/busy go to 0 asynchronously. After release, a new valid_in streams from beat0 correctly.
- Default parameters (N=8, LANES=4):
  - Stimulus: element e = e.
  - Response: 16 beats; beat k lanes = {4k+3, 4k+2, 4k+1, 4k}; m_last only on beat 15.
